// File: rtl/color_stream_feeder_pkg.sv
// Shared colour codes and feeder state encoding for the colour-sequence checker path.
package color_stream_feeder_pkg;

    localparam logic [1:0] COLOR_RED   = 2'b00;
    localparam logic [1:0] COLOR_GREEN = 2'b01;
    localparam logic [1:0] COLOR_BLUE  = 2'b10;
    localparam logic [1:0] COLOR_NONE  = 2'b11;

    typedef enum logic [2:0] {
        IDLE = 3'b001,
        SEND = 3'b010,
        GAP  = 3'b100
    } feeder_state_e;

endpackage

// File: rtl/color_stream_feeder_if.sv
// Burst handshake between the upstream source and the colour feeder.
interface color_stream_feeder_if #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4
);
    logic                   in_valid;
    logic                   in_ready;
    logic [2*MAX_LEN-1:0]   in_colors;
    logic [LEN_W-1:0]       in_len;

    modport master (output in_valid, in_colors, in_len, input in_ready);
    modport slave  (input in_valid, in_colors, in_len, output in_ready);
endinterface

// File: rtl/color_stream_feeder_shift_reg.sv
// Parallel-load colour buffer; shifts toward element 0 and back-fills with COLOR_NONE.
module color_shift_reg
    import color_stream_feeder_pkg::*;
#(
    parameter int MAX_LEN = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load,
    input  logic                     shift,
    input  logic [MAX_LEN-1:0][1:0]  din,
    output logic [1:0]               head
);
    logic [MAX_LEN-1:0][1:0] buf_q;

    for (genvar i = 0; i < MAX_LEN; i++) begin : g_elem
        logic [1:0] upper;
        if (i == MAX_LEN - 1) begin : g_top
            assign upper = COLOR_NONE;
        end else begin : g_mid
            assign upper = buf_q[i+1];
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst)        buf_q[i] <= COLOR_NONE;
            else if (load)  buf_q[i] <= din[i];
            else if (shift) buf_q[i] <= upper;
        end
    end

    assign head = buf_q[0];
endmodule

// File: rtl/color_stream_feeder.sv
// Serialises a packed colour burst onto a registered colour output, closing each burst with a
// separator. Define COLOR_FEEDER_BACKTOBACK_EN to accept the next burst during the separator cycle.
module color_stream_feeder
    import color_stream_feeder_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    color_stream_feeder_if.slave  up,
    output logic [1:0]            color,
    output logic                  busy,
    output logic                  done
);
    feeder_state_e           state, state_nx;
    logic                    armed;
    logic [LEN_W-1:0]        cnt, cnt_nx;
    logic [1:0]              color_nx;
    logic [LEN_W-1:0]        len_c;
    logic                    ready, accept, load, shift;
    logic [MAX_LEN-1:0][1:0] burst;
    logic [MAX_LEN:0][1:0]   burst_ext;
    logic [1:0]              head;

    assign burst     = up.in_colors;
    assign burst_ext = {COLOR_NONE, burst};
    assign len_c     = (up.in_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : up.in_len;

    // armed holds ready low until the first clock after reset release
`ifdef COLOR_FEEDER_BACKTOBACK_EN
    assign ready = armed && (state == IDLE || state == GAP);
`else
    assign ready = armed && (state == IDLE);
`endif
    assign up.in_ready = ready;
    assign accept      = up.in_valid && ready;

    // Element 0 goes straight to the colour register, so the buffer holds elements 1.. onward
    color_shift_reg #(.MAX_LEN(MAX_LEN)) u_buf (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .shift (shift),
        .din   (burst_ext[MAX_LEN:1]),
        .head  (head)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            color <= COLOR_NONE;
            cnt   <= '0;
            armed <= 1'b0;
        end else begin
            color <= color_nx;
            cnt   <= cnt_nx;
            armed <= 1'b1;
        end
    end

    always_comb begin
        state_nx = state;
        color_nx = COLOR_NONE;
        cnt_nx   = cnt;
        load     = 1'b0;
        shift    = 1'b0;
        unique case (state)
            IDLE: state_nx = IDLE;
            SEND: begin
                // cnt counts the colour on the output too, so 1 means the last one is showing
                if (cnt <= LEN_W'(1)) begin
                    state_nx = GAP;
                    cnt_nx   = '0;
                end else begin
                    color_nx = head;
                    shift    = 1'b1;
                    cnt_nx   = cnt - LEN_W'(1);
                end
            end
            GAP: state_nx = IDLE;
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
        if (accept) begin
            load   = 1'b1;
            cnt_nx = len_c;
            if (len_c == '0) begin
                state_nx = GAP;
            end else begin
                state_nx = SEND;
                color_nx = burst[0];
            end
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == GAP);
endmodule

// File: tb/tb_color_stream_feeder.sv
// Directed vector bench for color_stream_feeder (MAX_LEN=8).
module tb_color_stream_feeder;
    import color_stream_feeder_pkg::*;

    localparam int MAX_LEN = 8;
    localparam int LEN_W   = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] color;
    logic       busy, done;

    color_stream_feeder_if #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) bus ();

    color_stream_feeder #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .up    (bus),
        .color (color),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [15:0] colors;
        logic [3:0]  len;
        int          n;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[6];

`ifdef COLOR_FEEDER_BACKTOBACK_EN
    localparam int BN = 7;
    logic [1:0] bc[BN] = '{2'b10, 2'b10, 2'b11, 2'b01, 2'b00, 2'b11, 2'b11};
    int         bd[BN] = '{0, 0, 1, 0, 0, 1, 0};
`else
    localparam int BN = 8;
    logic [1:0] bc[BN] = '{2'b10, 2'b10, 2'b11, 2'b11, 2'b01, 2'b00, 2'b11, 2'b11};
    int         bd[BN] = '{0, 0, 1, 0, 0, 0, 1, 0};
`endif

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_ready();
        bit ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("accept_timeout", 32'(0), 32'(1));
    endtask

    task automatic run_burst(input int id, input logic [15:0] colors, input logic [3:0] len,
                             input int n, input logic [15:0] exp);
        bus.in_colors = colors;
        bus.in_len    = len;
        bus.in_valid  = 1'b1;
        wait_ready();
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.in_colors = ~colors;
        bus.in_len    = 4'd3;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            chk($sformatf("v%0d color[%0d]", id, k), 32'(color), 32'(exp[2*k+:2]));
            chk($sformatf("v%0d busy[%0d]", id, k), 32'(busy), 32'(1));
            chk($sformatf("v%0d done[%0d]", id, k), 32'(done), 32'(0));
        end
        @(negedge clk);
        chk($sformatf("v%0d gap color", id), 32'(color), 32'(COLOR_NONE));
        chk($sformatf("v%0d gap done", id), 32'(done), 32'(1));
        chk($sformatf("v%0d gap busy", id), 32'(busy), 32'(1));
        @(negedge clk);
        chk($sformatf("v%0d idle busy", id), 32'(busy), 32'(0));
        chk($sformatf("v%0d idle done", id), 32'(done), 32'(0));
        chk($sformatf("v%0d idle ready", id), 32'(bus.in_ready), 32'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit drop;
        vecs[0] = '{16'h0060, 4'd4,  4, 16'h0060};  // 00,00,10,01
        vecs[1] = '{16'hFFFF, 4'd0,  0, 16'h0000};  // zero length
        vecs[2] = '{16'hE4E4, 4'd12, 8, 16'hE4E4};  // clamped to 8
        vecs[3] = '{16'h0002, 4'd1,  1, 16'h0002};
        vecs[4] = '{16'hAA07, 4'd3,  3, 16'h0007};  // 11 inside burst
        vecs[5] = '{16'h5555, 4'd8,  8, 16'h5555};

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_colors = '0;
        bus.in_len    = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst color", 32'(color), 32'(COLOR_NONE));
        chk("rst busy", 32'(busy), 32'(0));
        chk("rst done", 32'(done), 32'(0));
        chk("rst ready", 32'(bus.in_ready), 32'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post-rst ready low", 32'(bus.in_ready), 32'(0));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("idle ready[%0d]", i), 32'(bus.in_ready), 32'(1));
            chk($sformatf("idle color[%0d]", i), 32'(color), 32'(COLOR_NONE));
            chk($sformatf("idle busy[%0d]", i), 32'(busy), 32'(0));
            chk($sformatf("idle done[%0d]", i), 32'(done), 32'(0));
        end

        for (int v = 0; v < 6; v++)
            run_burst(v, vecs[v].colors, vecs[v].len, vecs[v].n, vecs[v].exp);

        // Reset mid-burst: eight reds, async reset after the third
        bus.in_colors = 16'h0000;
        bus.in_len    = 4'd8;
        bus.in_valid  = 1'b1;
        wait_ready();
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("abort color[%0d]", k), 32'(color), 32'(COLOR_RED));
        end
        #2 rst = 1'b1;
        #1;
        chk("abort async color", 32'(color), 32'(COLOR_NONE));
        chk("abort async busy", 32'(busy), 32'(0));
        chk("abort async done", 32'(done), 32'(0));
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("abort no done[%0d]", i), 32'(done), 32'(0));
            chk($sformatf("abort no resume[%0d]", i), 32'(color), 32'(COLOR_NONE));
        end
        run_burst(10, vecs[0].colors, vecs[0].len, vecs[0].n, vecs[0].exp);

        // Second burst held on the bus while the first is still sending
        bus.in_colors = 16'h000A;
        bus.in_len    = 4'd2;
        bus.in_valid  = 1'b1;
        wait_ready();
        @(posedge clk);
        #1;
        bus.in_colors = 16'h0001;
        bus.in_len    = 4'd2;
        for (int i = 0; i < BN; i++) begin
            @(negedge clk);
            chk($sformatf("b2b color[%0d]", i), 32'(color), 32'(bc[i]));
            chk($sformatf("b2b done[%0d]", i), 32'(done), 32'(bd[i]));
            drop = bus.in_valid && bus.in_ready;
            @(posedge clk);
            #1;
            if (drop) bus.in_valid = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/color_stream_feeder.md
Name: color_stream_feeder

Overview:
- Upstream stage of the colour-sequence checker: accepts a packed burst of up to MAX_LEN 2-bit colour codes through a valid/ready handshake.
- Emits the burst one colour per clock on a registered color output that drives the checker's colour input directly.
- After every burst it emits one separator code (2'b11) so the checker returns to its initial state.
- Idles on 2'b11, so the checker never sees spurious colours.

Parameters:
- MAX_LEN, 8, maximum colours per burst (≥1).
- LEN_W, 4, width of in_len; must hold MAX_LEN.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  burst offered.
- in_ready  output  1  feeder can accept a burst this cycle.
- in_colors  input  2*MAX_LEN  packed colours; element k = bits [2k+1:2k]; element 0 is sent first.
- in_len  input  LEN_W  number of colours in burst.
- color  output  2  colour to checker: 00 red, 01 green, 10 blue, 11 none/separator.
- busy  output  1  high when state != IDLE.
- done  output  1  one-cycle pulse in the separator cycle.

Behaviour:
- Reset: one clock, clk; asynchronous active-high reset rst. While rst is high, state=IDLE, color=2'b11, busy=0, done=0, in_ready=0, and the shift buffer and remaining-count are cleared. Reset mid-burst aborts the burst immediately; the aborted data is not resumed. in_ready rises the cycle after rst deasserts.
- States:
  - IDLE: color=11, in_ready=1.
  - SEND: emits the buffered colours.
  - GAP: emits the separator.
- Handshake: the burst is accepted at the rising edge where in_valid && in_ready. The inputs are sampled at that edge only; later changes to the inputs are ignored.
- Accept at edge E with len L, where 1 ≤ L ≤ MAX_LEN:
  - After E: state=SEND, color=element 0.
  - After E+k, for 0 < k < L: color=element k.
  - After E+L: state=GAP, color=11, done=1.
  - After E+L+1: state=IDLE, done=0.
  - Latency from accept to first colour is one cycle. The output is fully registered, with no combinational path from the inputs to color.
- in_len = 0: the accept goes straight to GAP. One separator cycle is emitted, done pulses, and the block then returns to IDLE.
- in_len > MAX_LEN: clamped to MAX_LEN; the upper elements are never sent.
- Element value 2'b11 inside a burst: passed through unchanged. It counts as one of the L colours.
- Remaining-count: an LEN_W-bit down-counter loaded with the clamped L. SEND exits when the last element is emitted. No wrap-around is permitted; the counter never decrements below 0.
- in_valid while busy, without the feature: ignored, with no side effects. The upstream source must hold in_valid until it sees in_ready.
- done and busy: done is high only in GAP. busy is high in SEND and GAP.

Optional Feature:
- Macro: COLOR_FEEDER_BACKTOBACK_EN.
- Defined: in_ready is also 1 in GAP. An accept in GAP goes from GAP directly to SEND, or back to GAP if L=0. Bursts are then separated by exactly one 11 cycle, and done still pulses for the finished burst.
- Undefined: in_ready is 1 only in IDLE. Bursts are separated by at least two 11 cycles (GAP followed by IDLE).

Decomposition:
- Shared package holds:
  - Colour code constants: COLOR_RED=2'b00, COLOR_GREEN=2'b01, COLOR_BLUE=2'b10, COLOR_NONE=2'b11. These are shared with the checker.
  - The feeder state encoding: IDLE, SEND, GAP, one-hot 3-bit.
- One sub-module is natural: color_shift_reg, a MAX_LEN×2-bit parallel-load, shift-right-by-2 register with load/shift enables. Its low 2 bits drive the next colour, and it fills with COLOR_NONE on shift.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, release, hold in_valid=0 for 5 cycles -> color=11, busy=0, done=0, in_ready=1 throughout after release.
- Basic burst: in_colors element[0..3]=00,00,10,01, in_len=4, accepted at edge E -> color 00,00,10,01 on cycles E+0..E+3. Then 11 with done=1 at E+4, and IDLE at E+5.
- Zero length and clamp: in_len=0 -> exactly one cycle of 11 with done=1, busy=1 for one cycle. in_len=12 with MAX_LEN=8 -> exactly 8 colours, then the separator.
- Reset mid-burst: start an 8-colour burst, assert rst asynchronously after the 3rd colour -> color=11 and busy=0 immediately without waiting for a clock edge, no done pulse, and a new burst is accepted after release.
- Ignored offer while busy: hold in_valid=1 with different data during SEND -> the current burst is unchanged. Without the feature, the held burst is accepted at the first edge where in_ready=1.
- Back-to-back (COLOR_FEEDER_BACKTOBACK_EN): two 2-colour bursts 10,10 and 01,00 with in_valid held high -> color sequence 10,10,11,01,00,11 with no IDLE cycle between the bursts. Without the macro, the sequence is 10,10,11,11,01,00,11.
